// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the rv_mc_core multi-cycle RV32I core.
package rv_mc_pkg;

  typedef enum logic [2:0] {
    FETCH, FWAIT, DECODE, EXEC, MEM, MWAIT, WB, TRAP
  } state_e;

  typedef enum logic [1:0] {
    TRAP_NONE     = 2'd0,
    TRAP_ILLEGAL  = 2'd1,
    TRAP_MISALIGN = 2'd2,
    TRAP_ENV      = 2'd3
  } trap_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // Immediate extender: format is chosen by opcode, result is sign-extended.
  function automatic logic signed [31:0] imm_ext(input logic [31:0] ir);
    logic signed [31:0] v;
    case (ir[6:0])
      OPC_STORE:          v = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:         v = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: v = {ir[31:12], 12'b0};
      OPC_JAL:            v = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:            v = {{20{ir[31]}}, ir[31:20]};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rv_mc_lsu_align.sv
// Load/store lane steering: byte strobes, lane replication, load extraction
// with sign/zero extension, and natural-alignment checking.
module rv_mc_lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  input  logic            is_store,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [3:0]      strobe,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);
  import rv_mc_pkg::*;

  logic [XLEN-1:0] shifted;
  logic            sext;

  always_comb begin
    shifted    = load_word >> {lane, 3'b000};
    sext       = ~funct3[2];
    misaligned = 1'b0;
    strobe     = 4'b1111;
    wdata      = store_data;
    load_data  = load_word;
    case (funct3[1:0])
      2'b00: begin
        strobe    = 4'b0001 << lane;
        wdata     = {4{store_data[7:0]}};
        load_data = {{(XLEN-8){shifted[7] & sext}}, shifted[7:0]};
      end
      2'b01: begin
        misaligned = lane[0];
        strobe     = 4'b0011 << lane;
        wdata      = {2{store_data[15:0]}};
        load_data  = {{(XLEN-16){shifted[15] & sext}}, shifted[15:0]};
      end
      default: begin
        misaligned = (lane != 2'b00);
      end
    endcase
    if (!is_store) strobe = 4'b0000;
  end

endmodule

// File: rtl/rv_mc_core.sv
// Multi-cycle RV32I core with a single valid/ready memory port.
// Optional performance counters are enabled with macro RV_MC_PERF_CNT_EN.
module rv_mc_core #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              NREGS        = 32
) (
  input  logic            clk,
  input  logic            srst,
  output logic            mem_req,
  input  logic            mem_ready,
  output logic [3:0]      mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted,
  output logic [1:0]      trap_cause,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
);
  import rv_mc_pkg::*;

  localparam int              RIDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0]      NREGS_L = 6'(NREGS);
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

  state_e          state;
  trap_e           trap_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir;
  logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc4_q, pcimm_q, res_q;
  logic [XLEN-1:0] regs [NREGS];

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0 || {1'b0, idx} >= NREGS_L) return '0;
    return regs[idx[RIDX_W-1:0]];
  endfunction

  function automatic logic [XLEN-1:0] alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                          input logic [2:0] op, input logic alt);
    logic signed [XLEN-1:0] sa, sb;
    logic [4:0]             sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[4:0];
    case (op)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return XLEN'(sa < sb);
      3'd3:    return XLEN'(a < b);
      3'd4:    return a ^ b;
      3'd5:    return alt ? XLEN'(sa >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Decode-time legality and trap classification
  logic legal, writes_rd, rd_bad;
  always_comb begin
    legal     = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal     = (funct7 == 7'h00) || (funct7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        writes_rd = 1'b1;
      end
      OPC_OP_IMM: begin
        legal     = (f3 == 3'd1) ? (funct7 == 7'h00) :
                    (f3 == 3'd5) ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1;
        writes_rd = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_JALR: begin
        legal     = (f3 == 3'd0);
        writes_rd = 1'b1;
      end
      OPC_BRANCH: legal = (f3 != 3'd2) && (f3 != 3'd3);
      OPC_LOAD: begin
        legal     = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                    (f3 == F3_LBU) || (f3 == F3_LHU);
        writes_rd = 1'b1;
      end
      OPC_STORE:  legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
      OPC_SYSTEM: legal = (ir[31:21] == 11'd0) && (ir[19:7] == 13'd0);
      default:    legal = 1'b0;
    endcase
    rd_bad = writes_rd && ({1'b0, rd} >= NREGS_L);
  end

  // Execute-stage arithmetic on latched operands
  logic [XLEN-1:0] agu, jump_tgt, exec_res;
  logic            br_taken;
  assign agu      = rs1_q + imm_q;
  assign jump_tgt = (opcode == OPC_JALR) ? {agu[XLEN-1:1], 1'b0} : pcimm_q;

  always_comb begin
    case (f3)
      F3_BEQ:  br_taken = (rs1_q == rs2_q);
      F3_BNE:  br_taken = (rs1_q != rs2_q);
      F3_BLT:  br_taken = ($signed(rs1_q) < $signed(rs2_q));
      F3_BGE:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
      F3_BLTU: br_taken = (rs1_q < rs2_q);
      F3_BGEU: br_taken = (rs1_q >= rs2_q);
      default: br_taken = 1'b0;
    endcase
    case (opcode)
      OPC_LUI:   exec_res = imm_q;
      OPC_AUIPC: exec_res = pcimm_q;
      OPC_OP:    exec_res = alu(rs1_q, rs2_q, f3, ir[30]);
      default:   exec_res = alu(rs1_q, imm_q, f3, (f3 == 3'd5) && ir[30]);
    endcase
  end

  logic [3:0]      lsu_strobe;
  logic [XLEN-1:0] lsu_wdata, lsu_load;
  logic            lsu_misaligned;

  rv_mc_lsu_align #(.XLEN(XLEN)) u_lsu (
    .lane       (agu[1:0]),
    .funct3     (f3),
    .is_store   (opcode == OPC_STORE),
    .store_data (rs2_q),
    .load_word  (mem_rdata),
    .strobe     (lsu_strobe),
    .wdata      (lsu_wdata),
    .load_data  (lsu_load),
    .misaligned (lsu_misaligned)
  );

  // Commit: the single point where pc advances, rd is written and retire fires
  logic            commit, rf_we;
  logic [XLEN-1:0] next_pc, rf_wd;
  always_comb begin
    commit  = 1'b0;
    rf_we   = 1'b0;
    next_pc = pc4_q;
    rf_wd   = res_q;
    case (state)
      EXEC: begin
        if (opcode == OPC_BRANCH) begin
          commit  = 1'b1;
          next_pc = br_taken ? pcimm_q : pc4_q;
        end else if ((opcode == OPC_JAL || opcode == OPC_JALR) && jump_tgt[1:0] == 2'b00) begin
          commit  = 1'b1;
          next_pc = jump_tgt;
          rf_we   = 1'b1;
          rf_wd   = pc4_q;
        end
      end
      MEM:   commit = (opcode == OPC_STORE) && mem_req && mem_ready;
      MWAIT: begin
        commit = mem_rvalid;
        rf_we  = mem_rvalid;
        rf_wd  = lsu_load;
      end
      WB: begin
        commit = 1'b1;
        rf_we  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == FWAIT && mem_rvalid) ir <= mem_rdata[31:0];
    if (state == DECODE) begin
      rs1_q   <= rf_read(rs1);
      rs2_q   <= rf_read(rs2);
      imm_q   <= XLEN'(imm_ext(ir));
      pc4_q   <= pc_q + FOUR;
      pcimm_q <= pc_q + XLEN'(imm_ext(ir));
    end
    if (state == EXEC) res_q <= exec_res;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (rf_we && rd != 5'd0) begin
      regs[rd[RIDX_W-1:0]] <= rf_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= FETCH;
      pc_q      <= RESET_VECTOR;
      mem_req   <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= RESET_VECTOR;
      mem_wdata <= '0;
      retire    <= 1'b0;
      halted    <= 1'b0;
      trap_q    <= TRAP_NONE;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= pc_q;
            mem_we   <= 4'b0000;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= FWAIT;
          end
        end
        FWAIT: if (mem_rvalid) state <= DECODE;
        DECODE: begin
          if (!legal || rd_bad) begin
            state  <= TRAP;
            halted <= 1'b1;
            trap_q <= TRAP_ILLEGAL;
          end else if (opcode == OPC_SYSTEM) begin
            state  <= TRAP;
            halted <= 1'b1;
            trap_q <= TRAP_ENV;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          case (opcode)
            OPC_BRANCH: ;
            OPC_JAL, OPC_JALR: begin
              if (jump_tgt[1:0] != 2'b00) begin
                state  <= TRAP;
                halted <= 1'b1;
                trap_q <= TRAP_MISALIGN;
              end
            end
            OPC_LOAD, OPC_STORE: begin
              if (lsu_misaligned) begin
                state  <= TRAP;
                halted <= 1'b1;
                trap_q <= TRAP_MISALIGN;
              end else begin
                state     <= MEM;
                mem_req   <= 1'b1;
                mem_addr  <= agu;
                mem_we    <= lsu_strobe;
                mem_wdata <= lsu_wdata;
              end
            end
            default: state <= WB;
          endcase
        end
        MEM: begin
          if (mem_req && mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 4'b0000;
            state   <= MWAIT;
          end
        end
        MWAIT, WB: ;
        TRAP: mem_req <= 1'b0;
        default: state <= FETCH;
      endcase
      // A commit launches the next fetch straight away, overriding the above
      if (commit) begin
        pc_q     <= next_pc;
        retire   <= 1'b1;
        state    <= FETCH;
        mem_req  <= 1'b1;
        mem_addr <= next_pc;
        mem_we   <= 4'b0000;
      end
    end
  end

  assign pc         = pc_q;
  assign trap_cause = trap_q;

`ifdef RV_MC_PERF_CNT_EN
  logic [63:0] cyc_q, ins_q;
  always_ff @(posedge clk) begin
    if (srst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (!halted) cyc_q <= cyc_q + 64'd1;
      if (retire)  ins_q <= ins_q + 64'd1;
    end
  end
  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ins_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
